// File: rtl/oc8051_wb_pkg.sv
// Shared definitions for the oc8051 external data bus responder:
// bus widths, FSM state encoding and small address/counter helpers.
package oc8051_wb_pkg;

    localparam int WB_ADR_W = 16;
    localparam int WB_DAT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    // True when addr lies beyond an aw-bit implemented space; a full 16-bit space never overflows.
    function automatic logic is_oor(input logic [WB_ADR_W-1:0] addr, input int aw);
        logic r;
        if (aw >= WB_ADR_W) begin
            r = 1'b0;
        end else begin
            r = ((addr >> aw) != 16'd0);
        end
        return r;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/xram_wb_responder_if.sv
// Wishbone classic data-bus bundle between the oc8051 core (master) and the XRAM responder (slave).
interface xram_wb_responder_if;
    import oc8051_wb_pkg::*;

    logic                wbd_cyc_i;
    logic                wbd_stb_i;
    logic                wbd_we_i;
    logic [WB_ADR_W-1:0] wbd_adr_i;
    logic [WB_DAT_W-1:0] wbd_dat_i;
    logic [WB_DAT_W-1:0] wbd_dat_o;
    logic                wbd_ack_o;
    logic                wbd_err_o;

    modport slave (
        input  wbd_cyc_i, wbd_stb_i, wbd_we_i, wbd_adr_i, wbd_dat_i,
        output wbd_dat_o, wbd_ack_o, wbd_err_o
    );

    modport master (
        output wbd_cyc_i, wbd_stb_i, wbd_we_i, wbd_adr_i, wbd_dat_i,
        input  wbd_dat_o, wbd_ack_o, wbd_err_o
    );
endinterface

// File: rtl/xram_wb_responder_mem.sv
// Single-port synchronous byte RAM with a registered read port that only
// reloads on a read, so its output holds between reads.
module xram_byte_mem #(
    parameter int unsigned AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem_q [0:(2**AW)-1];
    logic [7:0] rdata_q;

    // Storage array: written on commit only, deliberately left uncleared by reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read-data register: loads on a read, otherwise keeps the last value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= 8'h00;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/xram_wb_responder.sv
// Wishbone classic responder backing oc8051 MOVX traffic with a byte XRAM,
// programmable wait states, out-of-range error and a write-commit strobe.
module xram_wb_responder
    import oc8051_wb_pkg::*;
#(
    parameter int unsigned MEM_AW      = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ERR_OOR     = 1
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    xram_wb_responder_if.slave     wbd,
    output logic                   wr_commit_o,
    output logic [WB_ADR_W-1:0]    wr_addr_o,
    output logic [WB_DAT_W-1:0]    wr_data_o,
    output logic [15:0]            rd_cnt_o,
    output logic [15:0]            wr_cnt_o
);
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_RESP  = ST_RESP;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic       ERR_EN  = (ERR_OOR != 0);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] adr_q, adr_d;
    logic        we_q, we_d;
    logic [7:0]  dat_q, dat_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        commit_q, commit_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic        req_s, go_resp_s, mem_we_s, mem_re_s;
    logic [7:0]  mem_rdata_s;

    assign req_s = wbd.wbd_cyc_i & wbd.wbd_stb_i;

    // Next-state logic: accept, count wait states, abort on dropped request, resolve the termination.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        we_d      = we_q;
        dat_d     = dat_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        commit_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        mem_we_s  = 1'b0;
        mem_re_s  = 1'b0;
        go_resp_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    adr_d = wbd.wbd_adr_i;
                    we_d  = wbd.wbd_we_i;
                    dat_d = wbd.wbd_dat_i;
                    if (WAIT_STATES == 0) begin
                        go_resp_s = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!req_s) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    go_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // The termination uses the *_d request fields so the zero-wait path sees the request being accepted.
        if (go_resp_s) begin
            state_d = S_RESP;
            if (ERR_EN && is_oor(adr_d, int'(MEM_AW))) begin
                err_d = 1'b1;
            end else if (we_d) begin
                ack_d     = 1'b1;
                mem_we_s  = 1'b1;
                commit_d  = 1'b1;
                wr_addr_d = adr_d;
                wr_data_d = dat_d;
                wr_cnt_d  = sat_inc16(wr_cnt_q);
            end else begin
                ack_d    = 1'b1;
                mem_re_s = 1'b1;
                rd_cnt_d = sat_inc16(rd_cnt_q);
            end
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // State, latched request and all registered outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            adr_q     <= 16'h0000;
            we_q      <= 1'b0;
            dat_q     <= 8'h00;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            commit_q  <= 1'b0;
            wr_addr_q <= 16'h0000;
            wr_data_q <= 8'h00;
            rd_cnt_q  <= 16'h0000;
            wr_cnt_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            we_q      <= we_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            commit_q  <= commit_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    // Out-of-range addresses wrap onto the low MEM_AW bits when errors are disabled.
    xram_byte_mem #(.AW(MEM_AW)) u_mem (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .we_i    (mem_we_s),
        .re_i    (mem_re_s),
        .addr_i  (adr_d[MEM_AW-1:0]),
        .wdata_i (dat_d),
        .rdata_o (mem_rdata_s)
    );

    assign wbd.wbd_dat_o = mem_rdata_s;
    assign wbd.wbd_ack_o = ack_q;
    assign wbd.wbd_err_o = err_q;
    assign wr_commit_o   = commit_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;
    assign rd_cnt_o      = rd_cnt_q;
    assign wr_cnt_o      = wr_cnt_q;
endmodule

// File: tb/tb_xram_wb_responder.sv
// Self-checking bench: four responder instances with different parameters,
// directed scenarios plus randomized traffic checked against a behavioural XRAM model.
module tb_xram_wb_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rst_v, cyc_v, stb_v, we_v;
    logic [15:0] adr_v [4];
    logic [7:0]  wdat_v [4];
    logic [3:0]  ack_v, err_v, commit_v;
    logic [7:0]  rdat_v [4];
    logic [15:0] wra_v [4];
    logic [7:0]  wrd_v [4];
    logic [15:0] rdc_v [4];
    logic [15:0] wrc_v [4];

    // Instance parameters: 0:(WS1,err) 1:(WS1,wrap) 2:(WS3,err) 3:(WS0,err); all MEM_AW=8.
    int ws_of [4]  = '{1, 1, 3, 0};
    bit oor_of [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned WS  = (g == 2) ? 3 : ((g == 3) ? 0 : 1);
        localparam int unsigned OOR = (g == 1) ? 0 : 1;
        xram_wb_responder_if bus ();
        assign bus.wbd_cyc_i = cyc_v[g];
        assign bus.wbd_stb_i = stb_v[g];
        assign bus.wbd_we_i  = we_v[g];
        assign bus.wbd_adr_i = adr_v[g];
        assign bus.wbd_dat_i = wdat_v[g];
        assign ack_v[g]      = bus.wbd_ack_o;
        assign err_v[g]      = bus.wbd_err_o;
        assign rdat_v[g]     = bus.wbd_dat_o;
        xram_wb_responder #(.MEM_AW(8), .WAIT_STATES(WS), .ERR_OOR(OOR)) dut (
            .wb_clk_i    (clk),
            .wb_rst_i    (rst_v[g]),
            .wbd         (bus.slave),
            .wr_commit_o (commit_v[g]),
            .wr_addr_o   (wra_v[g]),
            .wr_data_o   (wrd_v[g]),
            .rd_cnt_o    (rdc_v[g]),
            .wr_cnt_o    (wrc_v[g])
        );
    end

    // Behavioural model: byte arrays, validity, counters, last commit and read-data register.
    logic [7:0]  m_mem [4][256];
    bit          m_val [4][256];
    int unsigned m_rd [4];
    int unsigned m_wr [4];
    logic [15:0] m_wa [4];
    logic [7:0]  m_wd [4];
    logic [7:0]  m_dat [4];
    bit          m_dk [4];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_reset(input int d);
        m_rd[d] = 0; m_wr[d] = 0; m_wa[d] = 16'h0000; m_wd[d] = 8'h00;
        m_dat[d] = 8'h00; m_dk[d] = 1'b1;
    endtask

    // Apply one completed transaction to the model; returns whether it ends in an error.
    task automatic model_txn(input int d, input logic w, input logic [15:0] a,
                             input logic [7:0] dt, output bit e_err);
        int idx;
        idx = int'(a) % 256;
        e_err = oor_of[d] && (a >= 16'd256);
        if (!e_err) begin
            if (w) begin
                m_mem[d][idx] = dt; m_val[d][idx] = 1'b1;
                m_wa[d] = a; m_wd[d] = dt;
                if (m_wr[d] < 65535) m_wr[d]++;
            end else begin
                if (m_rd[d] < 65535) m_rd[d]++;
                m_dk[d] = m_val[d][idx];
                m_dat[d] = m_mem[d][idx];
            end
        end
    endtask

    // Drive one request and wait (bounded) for its termination; returns at the terminating cycle's negedge.
    task automatic do_txn(input int d, input logic w, input logic [15:0] a, input logic [7:0] dt,
                          output int lat, output logic o_ack, output logic o_err);
        @(negedge clk);
        cyc_v[d] = 1'b1; stb_v[d] = 1'b1; we_v[d] = w; adr_v[d] = a; wdat_v[d] = dt;
        lat = -1; o_ack = 1'b0; o_err = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (ack_v[d] || err_v[d]) begin
                lat = i; o_ack = ack_v[d]; o_err = err_v[d];
                break;
            end
        end
        cyc_v[d] = 1'b0; stb_v[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_v = 4'hF; cyc_v = 4'h0; stb_v = 4'h0; we_v = 4'h0;
        for (int d = 0; d < 4; d++) begin
            adr_v[d] = 16'h0000; wdat_v[d] = 8'h00; model_reset(d);
            for (int i = 0; i < 256; i++) m_val[d][i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if ({ack_v[d], err_v[d], commit_v[d], rdat_v[d], wra_v[d], wrd_v[d], rdc_v[d], wrc_v[d]} !== 67'd0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: ack=%b err=%b commit=%b dat=%h wra=%h wrd=%h rdc=%h wrc=%h, all must be 0",
                         d, ack_v[d], err_v[d], commit_v[d], rdat_v[d], wra_v[d], wrd_v[d], rdc_v[d], wrc_v[d]);
            end
        end
        rst_v = 4'h0;
    endtask

    task automatic test_write_read();
        int lat; logic a, e; bit ee;
        model_txn(0, 1'b1, 16'h0012, 8'hA5, ee);
        do_txn(0, 1'b1, 16'h0012, 8'hA5, lat, a, e);
        n_tests++;
        if (lat !== ws_of[0] + 1 || a !== 1'b1 || e !== 1'b0) begin
            n_fail++; $display("FAIL wr_ack: lat=%0d ack=%b err=%b, need lat=%0d ack=1 err=0", lat, a, e, ws_of[0] + 1);
        end
        n_tests++;
        if ({commit_v[0], wra_v[0], wrd_v[0]} !== {1'b1, 16'h0012, 8'hA5}) begin
            n_fail++; $display("FAIL wr_commit: commit=%b addr=%h data=%h, need 1/0012/a5", commit_v[0], wra_v[0], wrd_v[0]);
        end
        @(negedge clk);
        n_tests++;
        if (ack_v[0] !== 1'b0 || commit_v[0] !== 1'b0) begin
            n_fail++; $display("FAIL wr_single_pulse: ack=%b commit=%b one cycle later, need 0/0", ack_v[0], commit_v[0]);
        end
        model_txn(0, 1'b0, 16'h0012, 8'h00, ee);
        do_txn(0, 1'b0, 16'h0012, 8'h00, lat, a, e);
        n_tests++;
        if (lat !== ws_of[0] + 1 || a !== 1'b1 || rdat_v[0] !== 8'hA5) begin
            n_fail++; $display("FAIL rd_after_wr: lat=%0d ack=%b dat=%h, need lat=%0d ack=1 dat=a5", lat, a, rdat_v[0], ws_of[0] + 1);
        end
        n_tests++;
        if (rdc_v[0] !== 16'(m_rd[0]) || wrc_v[0] !== 16'(m_wr[0])) begin
            n_fail++; $display("FAIL wr_rd_counts: rd=%0d wr=%0d, need rd=%0d wr=%0d", rdc_v[0], wrc_v[0], m_rd[0], m_wr[0]);
        end
    endtask

    task automatic test_oor();
        int lat; logic a, e; bit ee;
        model_txn(0, 1'b0, 16'h0100, 8'h00, ee);
        do_txn(0, 1'b0, 16'h0100, 8'h00, lat, a, e);
        n_tests++;
        if (lat !== ws_of[0] + 1 || a !== 1'b0 || e !== 1'b1 || rdat_v[0] !== m_dat[0]) begin
            n_fail++; $display("FAIL oor_err: lat=%0d ack=%b err=%b dat=%h, need lat=%0d ack=0 err=1 dat=%h",
                               lat, a, e, rdat_v[0], ws_of[0] + 1, m_dat[0]);
        end
        @(negedge clk);
        n_tests++;
        if (err_v[0] !== 1'b0 || rdc_v[0] !== 16'(m_rd[0]) || wrc_v[0] !== 16'(m_wr[0])) begin
            n_fail++; $display("FAIL oor_after: err=%b rd=%0d wr=%0d, need err=0 rd=%0d wr=%0d",
                               err_v[0], rdc_v[0], wrc_v[0], m_rd[0], m_wr[0]);
        end
    endtask

    task automatic test_wrap();
        int lat; logic a, e; bit ee;
        model_txn(1, 1'b1, 16'h0105, 8'h3C, ee);
        do_txn(1, 1'b1, 16'h0105, 8'h3C, lat, a, e);
        n_tests++;
        if (a !== 1'b1 || e !== 1'b0 || commit_v[1] !== 1'b1 || wra_v[1] !== 16'h0105) begin
            n_fail++; $display("FAIL wrap_write: ack=%b err=%b commit=%b addr=%h, need 1/0/1/0105", a, e, commit_v[1], wra_v[1]);
        end
        model_txn(1, 1'b0, 16'h0005, 8'h00, ee);
        do_txn(1, 1'b0, 16'h0005, 8'h00, lat, a, e);
        n_tests++;
        if (a !== 1'b1 || rdat_v[1] !== 8'h3C) begin
            n_fail++; $display("FAIL wrap_read: ack=%b dat=%h, need ack=1 dat=3c", a, rdat_v[1]);
        end
    endtask

    task automatic test_abort();
        int lat; logic a, e; bit ee; logic seen;
        model_txn(2, 1'b1, 16'h0040, 8'h77, ee);
        do_txn(2, 1'b1, 16'h0040, 8'h77, lat, a, e);
        n_tests++;
        if (lat !== ws_of[2] + 1 || a !== 1'b1) begin
            n_fail++; $display("FAIL ws3_latency: lat=%0d ack=%b, need lat=%0d ack=1", lat, a, ws_of[2] + 1);
        end
        @(negedge clk);
        cyc_v[2] = 1'b1; stb_v[2] = 1'b1; we_v[2] = 1'b1; adr_v[2] = 16'h0040; wdat_v[2] = 8'hEE;
        seen = 1'b0;
        repeat (2) begin @(negedge clk); seen |= ack_v[2] | err_v[2] | commit_v[2]; end
        stb_v[2] = 1'b0;
        repeat (6) begin @(negedge clk); seen |= ack_v[2] | err_v[2] | commit_v[2]; end
        cyc_v[2] = 1'b0;
        n_tests++;
        if (seen !== 1'b0 || wrc_v[2] !== 16'(m_wr[2])) begin
            n_fail++; $display("FAIL abort_quiet: activity=%b wr=%0d, need activity=0 wr=%0d", seen, wrc_v[2], m_wr[2]);
        end
        model_txn(2, 1'b0, 16'h0040, 8'h00, ee);
        do_txn(2, 1'b0, 16'h0040, 8'h00, lat, a, e);
        n_tests++;
        if (a !== 1'b1 || rdat_v[2] !== m_dat[2]) begin
            n_fail++; $display("FAIL abort_prior_data: ack=%b dat=%h, need ack=1 dat=%h", a, rdat_v[2], m_dat[2]);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic a, e; bit ee; logic exp_ack;
        model_txn(3, 1'b1, 16'h0007, 8'h5A, ee);
        do_txn(3, 1'b1, 16'h0007, 8'h5A, lat, a, e);
        n_tests++;
        if (lat !== ws_of[3] + 1 || a !== 1'b1) begin
            n_fail++; $display("FAIL ws0_latency: lat=%0d ack=%b, need lat=%0d ack=1", lat, a, ws_of[3] + 1);
        end
        @(negedge clk);
        cyc_v[3] = 1'b1; stb_v[3] = 1'b1; we_v[3] = 1'b0; adr_v[3] = 16'h0007;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            exp_ack = (((j - 1) % (ws_of[3] + 2)) == ws_of[3]);
            if (exp_ack) model_txn(3, 1'b0, 16'h0007, 8'h00, ee);
            n_tests++;
            if (ack_v[3] !== exp_ack || (exp_ack && rdat_v[3] !== 8'h5A)) begin
                n_fail++; $display("FAIL b2b_cycle%0d: ack=%b dat=%h, need ack=%b dat=5a", j, ack_v[3], rdat_v[3], exp_ack);
            end
        end
        cyc_v[3] = 1'b0; stb_v[3] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rdc_v[3] !== 16'(m_rd[3]) || m_rd[3] != 6) begin
            n_fail++; $display("FAIL b2b_rd_cnt: rd=%0d, need %0d (6 reads)", rdc_v[3], m_rd[3]);
        end
    endtask

    task automatic test_saturation();
        int lat; logic a, e; bit ee;
        @(negedge clk);
        force g_dut[3].dut.wr_cnt_q = 16'hFFFE;
        @(negedge clk);
        release g_dut[3].dut.wr_cnt_q;
        m_wr[3] = 32'hFFFE;
        for (int k = 0; k < 3; k++) begin
            model_txn(3, 1'b1, 16'(16'h0080 + k), 8'(8'h10 + k), ee);
            do_txn(3, 1'b1, 16'(16'h0080 + k), 8'(8'h10 + k), lat, a, e);
            n_tests++;
            if (a !== 1'b1 || wrc_v[3] !== 16'(m_wr[3])) begin
                n_fail++; $display("FAIL sat_write%0d: ack=%b wr=%h, need ack=1 wr=%h", k, a, wrc_v[3], 16'(m_wr[3]));
            end
        end
    endtask

    task automatic test_random();
        int lat; logic a, e; bit ee; logic w; logic [15:0] ad; logic [7:0] dt;
        for (int n = 0; n < 40; n++) begin
            ad = ($urandom_range(0, 4) == 0) ? 16'($urandom) : {8'h00, 8'($urandom_range(0, 31))};
            w  = 1'($urandom_range(0, 1));
            dt = 8'($urandom);
            model_txn(0, w, ad, dt, ee);
            do_txn(0, w, ad, dt, lat, a, e);
            n_tests++;
            if (lat !== ws_of[0] + 1 || a !== !ee || e !== ee) begin
                n_fail++; $display("FAIL rnd%0d_term: adr=%h we=%b lat=%0d ack=%b err=%b, need lat=%0d ack=%b err=%b",
                                   n, ad, w, lat, a, e, ws_of[0] + 1, !ee, ee);
            end
            n_tests++;
            if (commit_v[0] !== (w && !ee) || (w && !ee && (wra_v[0] !== ad || wrd_v[0] !== dt))) begin
                n_fail++; $display("FAIL rnd%0d_commit: commit=%b addr=%h data=%h, need commit=%b addr=%h data=%h",
                                   n, commit_v[0], wra_v[0], wrd_v[0], w && !ee, ad, dt);
            end
            if (m_dk[0]) begin
                n_tests++;
                if (rdat_v[0] !== m_dat[0]) begin
                    n_fail++; $display("FAIL rnd%0d_data: dat=%h, need %h", n, rdat_v[0], m_dat[0]);
                end
            end
        end
        n_tests++;
        if (rdc_v[0] !== 16'(m_rd[0]) || wrc_v[0] !== 16'(m_wr[0])) begin
            n_fail++; $display("FAIL rnd_counts: rd=%0d wr=%0d, need rd=%0d wr=%0d", rdc_v[0], wrc_v[0], m_rd[0], m_wr[0]);
        end
    endtask

    task automatic test_async_reset();
        int lat; logic a, e; bit ee;
        model_txn(0, 1'b1, 16'h0033, 8'h11, ee);
        do_txn(0, 1'b1, 16'h0033, 8'h11, lat, a, e);
        @(negedge clk);
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1; we_v[0] = 1'b1; adr_v[0] = 16'h0033; wdat_v[0] = 8'h99;
        @(posedge clk);
        #2 rst_v[0] = 1'b1;
        #1;
        n_tests++;
        if ({ack_v[0], err_v[0], commit_v[0], rdat_v[0], wra_v[0], wrd_v[0], rdc_v[0], wrc_v[0]} !== 67'd0) begin
            n_fail++; $display("FAIL async_reset: ack=%b err=%b commit=%b dat=%h wra=%h wrd=%h rdc=%h wrc=%h, all must be 0",
                               ack_v[0], err_v[0], commit_v[0], rdat_v[0], wra_v[0], wrd_v[0], rdc_v[0], wrc_v[0]);
        end
        cyc_v[0] = 1'b0; stb_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_v[0] = 1'b0;
        model_reset(0);
        model_txn(0, 1'b0, 16'h0033, 8'h00, ee);
        do_txn(0, 1'b0, 16'h0033, 8'h00, lat, a, e);
        n_tests++;
        if (lat !== ws_of[0] + 1 || a !== 1'b1 || rdat_v[0] !== 8'h11) begin
            n_fail++; $display("FAIL post_reset_read: lat=%0d ack=%b dat=%h, need lat=%0d ack=1 dat=11", lat, a, rdat_v[0], ws_of[0] + 1);
        end
        n_tests++;
        if (rdc_v[0] !== 16'd1 || wrc_v[0] !== 16'd0) begin
            n_fail++; $display("FAIL post_reset_counts: rd=%0d wr=%0d, need rd=1 wr=0", rdc_v[0], wrc_v[0]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_oor();
        test_wrap();
        test_abort();
        test_back_to_back();
        test_saturation();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
